// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD seven-segment display block.
// Patterns are active-high {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic has_bad_nibble(
    input logic [11:0] v
  );
    return (v[3:0] > 4'd9) ||
           (v[7:4] > 4'd9) ||
           (v[11:8] > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_seg_display_bcd_to_seg.sv
// Combinational nibble to active-high segment pattern.
// Non-decimal codes render as a dash.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_DASH;
    unique case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_display.sv
// CPU BCD result bus to a multiplexed 3-digit common-anode display.
// Filters the async bus, latches per frame, scans one digit per slot.
module bcd_seg_display
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV      = 50000,
  parameter int GAP           = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  an,
  output logic        err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GAP = CW'(GAP);
  localparam logic [1:0]    IDX_MAX = 2'(NUM_DIGITS - 1);

  logic [11:0]   s1;
  logic [11:0]   s2;
  logic [11:0]   stable_r;
  logic [11:0]   disp_r;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          wrap;
  logic          frame;
  logic [3:0]    nib;
  logic          blank;
  logic          lit;
  logic [6:0]    pat;

  assign wrap  = (cnt == CNT_MAX);
  assign frame = wrap && (idx == IDX_MAX);
  assign dp    = 1'b1;

  // Only a value seen on two consecutive samples is trusted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= '0;
      s2       <= '0;
      stable_r <= '0;
    end else begin
      s1 <= bcd_in;
      s2 <= s1;
      if (s1 == s2)
        stable_r <= s2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? 2'd0 : idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_r <= '0;
      err    <= 1'b0;
    end else if (frame) begin
      disp_r <= stable_r;
      err    <= has_bad_nibble(stable_r);
    end
  end

  always_comb begin
    nib   = disp_r[3:0];
    blank = 1'b0;
    unique case (idx)
      2'd2: begin
        nib   = disp_r[11:8];
        blank = (BLANK_LEADING != 0) &&
                (disp_r[11:8] == 4'd0);
      end
      2'd1: begin
        nib   = disp_r[7:4];
        blank = (BLANK_LEADING != 0) &&
                (disp_r[11:4] == 8'd0);
      end
      default: begin
        nib   = disp_r[3:0];
        blank = 1'b0;
      end
    endcase
  end

  bcd_to_seg u_dec (
    .nib (nib),
    .pat (pat)
  );

  assign lit = (cnt >= CNT_GAP) && !blank;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 3'b111;
      seg <= ~SEG_BLANK;
    end else begin
      an  <= lit ? ~(3'b001 << idx) : 3'b111;
      seg <= lit ? ~pat : ~SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Randomized and directed bench for bcd_seg_display.
// Model works from absolute cycle position and a sample history.
module tb_bcd_seg_display;

  localparam int SD = 8;
  localparam int GP = 2;

  logic        clk;
  logic        reset;
  logic [11:0] bcd_in;
  logic [6:0]  seg, seg_nb;
  logic        dp, dp_nb;
  logic [2:0]  an, an_nb;
  logic        err, err_nb;

  int checks = 0;
  int errors = 0;

  int          m_k;
  logic [11:0] m_hist0, m_hist1;
  logic [11:0] m_stable, m_disp;
  logic        m_err;
  logic [2:0]  e_an [2];
  logic [6:0]  e_seg [2];

  bcd_seg_display #(
    .SCAN_DIV(SD), .GAP(GP), .BLANK_LEADING(1)
  ) u_dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in),
    .seg(seg), .dp(dp), .an(an), .err(err)
  );

  bcd_seg_display #(
    .SCAN_DIV(SD), .GAP(GP), .BLANK_LEADING(0)
  ) u_nb (
    .clk(clk), .reset(reset), .bcd_in(bcd_in),
    .seg(seg_nb), .dp(dp_nb), .an(an_nb), .err(err_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low segment codes of each displayed character.
  function automatic logic [6:0] seg_lo(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic any_bad(input logic [11:0] v);
    int x;
    x = v;
    for (int i = 0; i < 3; i++) begin
      if (x % 16 > 9) return 1'b1;
      x = x / 16;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_k = 0;
    m_hist0 = 0;
    m_hist1 = 0;
    m_stable = 0;
    m_disp = 0;
    m_err = 0;
    for (int b = 0; b < 2; b++) begin
      e_an[b] = 3'b111;
      e_seg[b] = 7'h7F;
    end
  endtask

  task automatic tick();
    int slot, off, d, h, t;
    bit blank, lit;
    @(posedge clk);
    slot = (m_k / SD) % 3;
    off = m_k % SD;
    d = (int'(m_disp) >> (4 * slot)) % 16;
    h = (int'(m_disp) >> 8) % 16;
    t = (int'(m_disp) >> 4) % 16;
    for (int b = 0; b < 2; b++) begin
      blank = (b == 0) &&
              ((slot == 2 && h == 0) ||
               (slot == 1 && h == 0 && t == 0));
      lit = (off >= GP) && !blank;
      e_an[b] = lit ? 3'(7 - (1 << slot)) : 3'b111;
      e_seg[b] = lit ? seg_lo(d) : 7'h7F;
    end
    if (off == SD - 1 && slot == 2) begin
      m_disp = m_stable;
      m_err = any_bad(m_stable);
    end
    if (m_hist0 == m_hist1) m_stable = m_hist1;
    m_hist1 = m_hist0;
    m_hist0 = bcd_in;
    m_k++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bcd_in = 12'h000;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({seg, an, dp, err} !== {7'h7F, 3'b111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state seg=%h an=%b dp=%b err=%b want 7f 111 1 0",
               seg, an, dp, err);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if ({an, seg, err, an_nb, seg_nb, err_nb} !==
          {e_an[0], e_seg[0], m_err, e_an[1], e_seg[1], m_err}) begin
        errors++;
        $display("FAIL post_reset k=%0d an=%b seg=%h nb=%b/%h want %b/%h %b/%h",
                 m_k, an, seg, an_nb, seg_nb, e_an[0], e_seg[0], e_an[1], e_seg[1]);
      end
    end
  endtask

  task automatic test_digits_123();
    int n30, n24, n79, nother;
    bcd_in = 12'h123;
    for (int i = 0; i < 72; i++) begin
      tick();
      checks++;
      if ({an, seg, err, an_nb, seg_nb, err_nb} !==
          {e_an[0], e_seg[0], m_err, e_an[1], e_seg[1], m_err}) begin
        errors++;
        $display("FAIL d123 k=%0d an=%b seg=%h want %b %h", m_k, an, seg, e_an[0], e_seg[0]);
      end
    end
    n30 = 0; n24 = 0; n79 = 0; nother = 0;
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      if (an == 3'b110 && seg == 7'h30) n30++;
      else if (an == 3'b101 && seg == 7'h24) n24++;
      else if (an == 3'b011 && seg == 7'h79) n79++;
      else if (!(an == 3'b111 && seg == 7'h7F)) nother++;
    end
    checks++;
    if ({n30, n24, n79, nother} !== {SD - GP, SD - GP, SD - GP, 0}) begin
      errors++;
      $display("FAIL frame_123 counts=%0d/%0d/%0d other=%0d want %0d each, 0",
               n30, n24, n79, nother, SD - GP);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (m_k % (3 * SD) != SD + 5 && guard < 3 * SD) begin
      tick();
      guard++;
    end
    checks++;
    if (an !== 3'b101 || seg !== 7'h24) begin
      errors++;
      $display("FAIL pre_reset an=%b seg=%h want 101 24", an, seg);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({seg, an, err} !== {7'h7F, 3'b111, 1'b0}) begin
      errors++;
      $display("FAIL async_reset seg=%h an=%b err=%b want 7f 111 0", seg, an, err);
    end
    model_reset();
    @(negedge clk);
    bcd_in = 12'h000;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (an !== ((i == 2) ? 3'b110 : 3'b111) || an !== e_an[0]) begin
        errors++;
        $display("FAIL restart i=%0d an=%b want %b", i, an, (i == 2) ? 3'b110 : 3'b111);
      end
    end
    checks++;
    if (seg !== 7'h40) begin
      errors++;
      $display("FAIL restart_seg seg=%h want 40", seg);
    end
  endtask

  task automatic test_blanking_007();
    int bad_an, n7, nb_lit;
    bcd_in = 12'h007;
    for (int i = 0; i < 72; i++) begin
      tick();
      checks++;
      if ({an, seg, err, an_nb, seg_nb, err_nb} !==
          {e_an[0], e_seg[0], m_err, e_an[1], e_seg[1], m_err}) begin
        errors++;
        $display("FAIL d007 k=%0d an=%b seg=%h nb=%b/%h", m_k, an, seg, an_nb, seg_nb);
      end
    end
    bad_an = 0; n7 = 0; nb_lit = 0;
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      if (an != 3'b111 && an != 3'b110) bad_an++;
      if (an == 3'b110 && seg == 7'h78) n7++;
      if ((an_nb == 3'b110 && seg_nb == 7'h78) ||
          (an_nb == 3'b101 && seg_nb == 7'h40) ||
          (an_nb == 3'b011 && seg_nb == 7'h40)) nb_lit++;
    end
    checks++;
    if (bad_an !== 0 || n7 !== SD - GP) begin
      errors++;
      $display("FAIL blank_007 bad_an=%0d n7=%0d want 0 %0d", bad_an, n7, SD - GP);
    end
    checks++;
    if (nb_lit !== 3 * (SD - GP)) begin
      errors++;
      $display("FAIL noblank_007 lit=%0d want %0d", nb_lit, 3 * (SD - GP));
    end
  endtask

  task automatic test_err_dash();
    int ndash, nerr0, nzero;
    bcd_in = 12'h1A5;
    for (int i = 0; i < 60; i++) tick();
    ndash = 0; nerr0 = 0;
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      if (an == 3'b101 && seg == 7'h3F) ndash++;
      if (err !== 1'b1) nerr0++;
      checks++;
      if ({an, seg, err} !== {e_an[0], e_seg[0], m_err}) begin
        errors++;
        $display("FAIL dash k=%0d an=%b seg=%h err=%b", m_k, an, seg, err);
      end
    end
    checks++;
    if (ndash !== SD - GP || nerr0 !== 0) begin
      errors++;
      $display("FAIL err_frame dash=%0d err_low=%0d want %0d 0", ndash, nerr0, SD - GP);
    end
    bcd_in = 12'h105;
    for (int i = 0; i < 60; i++) tick();
    nzero = 0;
    for (int i = 0; i < 3 * SD; i++) begin
      tick();
      if (an == 3'b101 && seg == 7'h40) nzero++;
    end
    checks++;
    if (nzero !== SD - GP || err !== 1'b0) begin
      errors++;
      $display("FAIL tens_zero n=%0d err=%b want %0d 0", nzero, err, SD - GP);
    end
  endtask

  task automatic test_glitch();
    int saw9, saw_st;
    bcd_in = 12'h123;
    for (int i = 0; i < 10; i++) tick();
    saw9 = 0; saw_st = 0;
    bcd_in = 12'h999;
    tick();
    bcd_in = 12'h123;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (u_dut.stable_r == 12'h999) saw_st++;
      if (an != 3'b111 && seg == 7'h10) saw9++;
      checks++;
      if ({an, seg, err} !== {e_an[0], e_seg[0], m_err}) begin
        errors++;
        $display("FAIL glitch k=%0d an=%b seg=%h", m_k, an, seg);
      end
    end
    checks++;
    if (saw9 !== 0 || saw_st !== 0) begin
      errors++;
      $display("FAIL glitch_seen nine=%0d stable=%0d want 0 0", saw9, saw_st);
    end
  endtask

  task automatic test_midframe();
    int guard, lat, stale;
    bit hit;
    guard = 0;
    while ((m_k / SD) % 3 != 1 && guard < 3 * SD) begin
      tick();
      guard++;
    end
    bcd_in = 12'h456;
    lat = 0; hit = 0; stale = 0;
    while (!hit && lat < 3 + 3 * SD + 1 + SD) begin
      tick();
      lat++;
      if (an == 3'b011 && seg != 7'h79) stale++;
      checks++;
      if ({an, seg, err} !== {e_an[0], e_seg[0], m_err}) begin
        errors++;
        $display("FAIL midframe k=%0d an=%b seg=%h", m_k, an, seg);
      end
      if (an == 3'b110 && seg == 7'h02) hit = 1;
    end
    checks++;
    if (!hit || lat > 3 + 3 * SD + 1 || stale != 0) begin
      errors++;
      $display("FAIL latency hit=%0d cycles=%0d stale=%0d want 1 <=%0d 0",
               hit, lat, stale, 3 + 3 * SD + 1);
    end
  endtask

  task automatic test_random();
    int hold;
    logic [11:0] v;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3, 0) == 0) v = 12'($urandom);
      else begin
        v[3:0] = 4'($urandom_range(9, 0));
        v[7:4] = 4'($urandom_range(1, 0) ? 0 : $urandom_range(9, 0));
        v[11:8] = 4'($urandom_range(1, 0) ? 0 : $urandom_range(9, 0));
      end
      bcd_in = v;
      hold = $urandom_range(40, 1);
      for (int i = 0; i < hold; i++) begin
        tick();
        checks++;
        if ({an, seg, err, dp, an_nb, seg_nb, err_nb, dp_nb} !==
            {e_an[0], e_seg[0], m_err, 1'b1, e_an[1], e_seg[1], m_err, 1'b1}) begin
          errors++;
          $display("FAIL random k=%0d in=%h an=%b seg=%h err=%b nb=%b/%h want %b/%h/%b %b/%h",
                   m_k, bcd_in, an, seg, err, an_nb, seg_nb,
                   e_an[0], e_seg[0], m_err, e_an[1], e_seg[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits_123();
    test_async_reset();
    test_blanking_007();
    test_err_dash();
    test_glitch();
    test_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
